countdown_timer_ctrl: RTL

Controller that sequences a loadable 4-bit down-counter as a programmable countdown timer.
- Accepts start/stop/pause commands and an optional clock prescale.
- Reports the count, a busy/paused status and a one-cycle done pulse at terminal count.
- Optionally auto-reloads for periodic operation.
- Sits between control logic and the down-counter datapath, which it instantiates and drives.

---
 rtl/timer_pkg.sv | 14 +
 rtl/down_counter_core.sv | 38 +++
 rtl/countdown_timer_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer: state encoding,
// default counter width and prescaler width.
package timer_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int PSC_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

endpackage

// File: rtl/down_counter_core.sv
// Loadable down-counter datapath; load beats enable, decrement saturates at 0.
// One-cycle latency from load/en to q; no backpressure (accepts every cycle).
module down_counter_core #(
  parameter int WIDTH = timer_pkg::WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             is_one
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end else if (en && (q_q != '0)) begin
      q_d = q_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign is_one = (q_q == WIDTH'(1));

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer sequencer: FSM, prescaler and reload register around a down-counter.
// All outputs registered (one-cycle command latency); no backpressure, commands act every cycle.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);
  localparam logic [PSC_W-1:0] PSC_ONE  = PSC_W'(1);

  state_e           state_q, state_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             paused_q, paused_d;

  logic             tick;
  logic             cnt_load;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_d;
  logic             cnt_is_one;

  down_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (cnt_load),
    .en     (cnt_en),
    .d      (cnt_d),
    .q      (count),
    .is_one (cnt_is_one)
  );

  // Priority chain: illegal state > stop > start > pause > tick.
  always_comb begin
    state_d  = state_q;
    psc_d    = psc_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_d    = '0;
    tick     = (state_q == RUN) && (psc_q == PSC_LAST);

    if (!(state_q inside {IDLE, RUN, PAUSE})) begin
      state_d  = IDLE;
      psc_d    = '0;
      cnt_load = 1'b1;
    end else if (stop) begin
      state_d  = IDLE;
      psc_d    = '0;
      cnt_load = 1'b1;
    end else if (start) begin
      psc_d    = '0;
      cnt_load = 1'b1;
      if (load_val != '0) begin
        reload_d = load_val;
        cnt_d    = load_val;
        state_d  = RUN;
      end else begin
        state_d  = IDLE;
        done_d   = 1'b1;
      end
    end else if (state_q == RUN) begin
      if (pause) begin
        state_d = PAUSE;
      end else if (tick) begin
        psc_d = '0;
        if (cnt_is_one) begin
          done_d   = 1'b1;
          cnt_load = 1'b1;
          if (auto_reload) begin
            cnt_d = reload_q;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end else begin
        psc_d = psc_q + PSC_ONE;
      end
    end else if ((state_q == PAUSE) && !pause) begin
      state_d = RUN;
    end

    busy_d   = (state_d == RUN) || (state_d == PAUSE);
    paused_d = (state_d == PAUSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      psc_q    <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      psc_q    <= psc_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
    end
  end

  assign busy   = busy_q;
  assign paused = paused_q;
  assign done   = done_q;

endmodule
